hsl_rr_tx_arbiter: RTL and testbench



---
 rtl/hsl_rr_arb_pkg.sv | 33 +++
 rtl/alt_lut6.sv | 17 +
 rtl/hsl_rr_grant_lut.sv | 23 ++
 rtl/hsl_rr_tx_arbiter.sv | 91 +++++++++
 tb/tb_hsl_rr_tx_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/hsl_rr_arb_pkg.sv
// Shared types and LUT mask generation for the HSL TX round-robin arbiter.
// The grant masks are evaluated at elaboration time.
package hsl_rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index = {ptr[1:0], req[3:0]}; bit set iff k wins the cyclic search.
  function automatic logic [63:0] rr_grant_mask(input int k);
    logic [63:0] m;
    logic [5:0]  ix;
    logic [3:0]  r;
    int          p;
    int          w;
    m = '0;
    for (int idx = 0; idx < 64; idx++) begin
      ix = 6'(idx);
      r  = ix[3:0];
      p  = int'(ix[5:4]);
      w  = -1;
      for (int s = 0; s < N_REQ; s++) begin
        if (w < 0 && r[(p + s) % N_REQ]) w = (p + s) % N_REQ;
      end
      m[idx] = (w == k);
    end
    return m;
  endfunction

endpackage

// File: rtl/alt_lut6.sv
// Six-input lookup cell; MASK bit din drives the output.
// SIM_EMULATE selects a direct indexed read instead of the masked reduction.
module alt_lut6 #(
  parameter logic [63:0] MASK        = '0,
  parameter logic        SIM_EMULATE = 1'b0
) (
  input  logic [5:0] din,
  output logic       dout
);

  if (SIM_EMULATE) begin : g_emu
    assign dout = MASK[din];
  end else begin : g_cell
    assign dout = |(MASK & (64'd1 << din));
  end

endmodule

// File: rtl/hsl_rr_grant_lut.sv
// Round-robin grant function: one LUT6 per grant bit.
// Output is one-hot, or zero when no request is present.
module hsl_rr_grant_lut
  import hsl_rr_arb_pkg::*;
#(
  parameter logic SIM_EMULATE = 1'b0
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] gnt
);

  for (genvar k = 0; k < N_REQ; k++) begin : g_lut
    alt_lut6 #(
      .MASK        (rr_grant_mask(k)),
      .SIM_EMULATE (SIM_EMULATE)
    ) u_lut (
      .din  ({ptr, req}),
      .dout (gnt[k])
    );
  end

endmodule

// File: rtl/hsl_rr_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one HSL TX stream
// between four sources.
module hsl_rr_tx_arbiter
  import hsl_rr_arb_pkg::*;
#(
  parameter int   WIDTH       = 64,
  parameter logic SIM_EMULATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]       in_last,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);

  state_t           state;
  logic [1:0]       ptr;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] lut_gnt;
  logic [N_REQ-1:0] sel;
  logic [1:0]       gidx;
  logic             xfer;

  hsl_rr_grant_lut #(
    .SIM_EMULATE (SIM_EMULATE)
  ) u_lut (
    .req (in_valid),
    .ptr (ptr),
    .gnt (lut_gnt)
  );

  // Outputs are forced quiet while reset is held.
  assign sel   = reset ? '0 : gnt_q;
  assign grant = gnt_q;
  assign busy  = (state == LOCKED);

  assign out_valid = |(in_valid & sel);
  assign out_last  = |(in_last & sel);
  assign in_ready  = sel & {N_REQ{out_ready}};
  assign xfer      = out_valid & out_ready;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      out_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}};
    end
  end

  always_comb begin
    gidx = 2'd0;
    unique case (1'b1)
      gnt_q[1]: gidx = 2'd1;
      gnt_q[2]: gidx = 2'd2;
      gnt_q[3]: gidx = 2'd3;
      default:  gidx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            gnt_q <= lut_gnt;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && out_last) begin
            ptr   <= gidx + 2'd1;
            gnt_q <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsl_rr_tx_arbiter.sv
// Scoreboard bench for hsl_rr_tx_arbiter: packet-level reference
// model feeds an expected-beat queue drained by a separate monitor.
module tb_hsl_rr_tx_arbiter;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_last;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [3:0]     grant;
  logic           busy;

  always #5 clk = ~clk;

  hsl_rr_tx_arbiter #(
    .WIDTH       (W),
    .SIM_EMULATE (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0] src;
    beat_t      b;
  } exp_t;

  beat_t src_q[4][$];
  exp_t  exp_q[$];

  int checks = 0;
  int failures = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int max_len = 1;
  int seq = 0;
  bit all_on = 1'b1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refill(input int i);
    int len;
    if (src_q[i].size() == 0) begin
      len = $urandom_range(1, max_len);
      for (int k = 0; k < len; k++) begin
        src_q[i].push_back({(k == len - 1), 8'(i), 24'(seq), $urandom()});
        seq++;
      end
    end
  endtask

  // Drive one cycle, check model state, advance model across the edge.
  task automatic step(input bit rst);
    int    w;
    beat_t b;
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < 4; i++) begin
      refill(i);
      in_data[i*W +: W] = src_q[i][0].data;
      in_last[i]        = src_q[i][0].last;
      in_valid[i]       = all_on ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    out_ready = all_on ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    chk("grant", 64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    chk("out_valid", 64'(out_valid),
        64'(!rst && m_owner >= 0 && in_valid[m_owner & 3]));
    if (rst) begin
      if (m_owner >= 0) begin
        while (src_q[m_owner].size() > 0 && !src_q[m_owner][0].last)
          void'(src_q[m_owner].pop_front());
        if (src_q[m_owner].size() > 0) void'(src_q[m_owner].pop_front());
      end
      m_owner = -1;
      m_ptr = 0;
      exp_q.delete();
    end else if (m_owner < 0) begin
      w = -1;
      for (int s = 0; s < 4; s++)
        if (w < 0 && in_valid[(m_ptr + s) % 4]) w = (m_ptr + s) % 4;
      if (w >= 0) begin
        m_owner = w;
        for (int k = 0; k < src_q[w].size(); k++) begin
          exp_q.push_back({2'(w), src_q[w][k]});
          if (src_q[w][k].last) break;
        end
      end
    end else if (in_valid[m_owner] && out_ready) begin
      b = src_q[m_owner].pop_front();
      if (b.last) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  // Monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (in_valid !== 4'bxxxx) begin
      chk("in_ready", 64'(in_ready),
          reset ? 64'd0 : 64'(grant & {4{out_ready}}));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.b.data);
          chk("beat_last", 64'(out_last), 64'(e.b.last));
          chk("beat_owner", 64'(grant), 64'd1 << e.src);
        end
      end
    end
  end

  logic [3:0] fair_seq [8];

  initial begin
    fair_seq[0] = 4'b0000; fair_seq[1] = 4'b0010;
    fair_seq[2] = 4'b0000; fair_seq[3] = 4'b0100;
    fair_seq[4] = 4'b0000; fair_seq[5] = 4'b1000;
    fair_seq[6] = 4'b0000; fair_seq[7] = 4'b0001;

    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("release_grant", 64'(grant), 64'd1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      chk("fair_seq", 64'(grant), 64'(fair_seq[k]));
    end

    all_on = 1'b0;
    max_len = 5;
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 249) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
